// File: rtl/sram_block_copy.sv
`default_nettype none
// ============================================================================
// Module   : sram_block_copy
// Brief    : Block-copy / fill engine for the local bus of icoboard_sram.
//            Copies a run of 16-bit words between SRAM regions, choosing the
//            direction so that overlapping regions behave like memmove, or
//            fills a region with a constant word.
// Revision : 1.0 - initial release
// ============================================================================
module sram_block_copy #(
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  lower_byte,
  output logic                  upper_byte,
  input  logic [DATA_WIDTH-1:0] read_data
);

  // Wait counter is at least one bit wide even for a single-cycle latency.
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  fill_q;
  logic                  desc_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic [WAIT_W-1:0]     wait_cnt;

  logic [ADDR_WIDTH-1:0] gap;
  logic                  start_desc;
  logic [ADDR_WIDTH-1:0] src_first;
  logic [ADDR_WIDTH-1:0] dst_first;
  logic [ADDR_WIDTH-1:0] src_step;
  logic [ADDR_WIDTH-1:0] dst_step;
  logic [ADDR_WIDTH:0]   words_next;
  logic                  last_word;

  // A copy must run downwards when the destination starts inside the source
  // window (measured modulo the address space), otherwise the source tail
  // would be overwritten before it is read.
  assign gap        = dst - src;
  assign start_desc = !fill && (dst != src) && ({1'b0, gap} < len);
  assign src_first  = start_desc ? (src + len[ADDR_WIDTH-1:0] - ADDR_ONE) : src;
  assign dst_first  = start_desc ? (dst + len[ADDR_WIDTH-1:0] - ADDR_ONE) : dst;

  assign src_step   = desc_q ? (src_ptr - ADDR_ONE) : (src_ptr + ADDR_ONE);
  assign dst_step   = desc_q ? (dst_ptr - ADDR_ONE) : (dst_ptr + ADDR_ONE);
  assign words_next = words_done + COUNT_ONE;
  assign last_word  = (words_next == len_q);

  // Full 16-bit word accesses only.
  assign lower_byte = 1'b1;
  assign upper_byte = 1'b1;

  // Sequencer: every bus output is registered and set up on the edge that
  // enters the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      words_done   <= '0;
      address      <= '0;
      write_enable <= 1'b0;
      write_data   <= '0;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      len_q        <= '0;
      fill_q       <= 1'b0;
      desc_q       <= 1'b0;
      fill_data_q  <= '0;
      wait_cnt     <= '0;
    end else begin
      done         <= 1'b0;
      write_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q       <= len;
            fill_q      <= fill;
            fill_data_q <= fill_data;
            desc_q      <= start_desc;
            src_ptr     <= src_first;
            dst_ptr     <= dst_first;
            words_done  <= '0;
            aborted     <= 1'b0;
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (fill) begin
              state        <= ST_WR;
              busy         <= 1'b1;
              address      <= dst_first;
              write_enable <= 1'b1;
              write_data   <= fill_data;
            end else begin
              state   <= ST_RD;
              busy    <= 1'b1;
              address <= src_first;
            end
          end
        end

        ST_RD: begin
          if (abort) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            // write_data doubles as the read holding register
            state        <= ST_WR;
            write_data   <= read_data;
            address      <= dst_ptr;
            write_enable <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_WR: begin
          words_done <= words_next;
          src_ptr    <= src_step;
          dst_ptr    <= dst_step;
          if (abort || last_word) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            aborted <= abort;
          end else if (fill_q) begin
            state        <= ST_WR;
            address      <= dst_step;
            write_enable <= 1'b1;
            write_data   <= fill_data_q;
          end else begin
            state   <= ST_RD;
            address <= src_step;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
